// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: idle-high line, start, LSB-first data, stop.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between data and stop.
module serial_frame_receiver #(
    parameter int BIT_CYCLES = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 g_rst,
    input  logic                 signal_input,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy,
    output logic [15:0]          frame_count
);

    localparam int CW = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 2);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);
    localparam logic [4:0]    LAST_BIT  = 5'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 sync1;
    logic                 sync2;
    logic                 hist;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [4:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 fall;
    logic                 tick;

    assign fall = hist & ~sync2;
    assign tick = (cnt == '0);
    assign busy = (state != S_IDLE);

`ifdef SERIAL_RX_PARITY_EN
    logic par_ok;
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (g_rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            hist        <= 1'b1;
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
`ifdef SERIAL_RX_PARITY_EN
            parity_error <= 1'b0;
            par_ok       <= 1'b1;
`endif
        end else begin
            sync1       <= signal_input;
            sync2       <= sync1;
            hist        <= sync2;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (sync2) begin
                        state <= S_IDLE;
                    end else begin
                        state   <= S_DATA;
                        cnt     <= FULL_LOAD;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= FULL_LOAD;
                        shreg <= (shreg >> 1)
                               | (DATA_BITS'(sync2) << (DATA_BITS - 1));
                        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= FULL_LOAD;
                        state <= S_STOP;
`ifdef SERIAL_RX_PARITY_EN
                        par_ok <= (sync2 == ^shreg);
`endif
                    end
                end
                S_STOP: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (!sync2) begin
                        // Line low at stop: wait for it to go high in BREAK.
                        frame_error <= 1'b1;
                        state       <= S_BREAK;
`ifdef SERIAL_RX_PARITY_EN
                    end else if (!par_ok) begin
                        parity_error <= 1'b1;
                        state        <= S_IDLE;
`endif
                    end else begin
                        data_out    <= shreg;
                        data_valid  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        state       <= S_IDLE;
                    end
                end
                S_BREAK: begin
                    if (sync2) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver at default parameters.
// Parity cases are built only when SERIAL_RX_PARITY_EN is defined.
module tb_serial_frame_receiver;

`ifdef SERIAL_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int BC        = 16;
    localparam int DV_OFF    = 2 + BC / 2 + (8 + 1 + PB) * BC;
    localparam int FRAME_LEN = (10 + PB) * BC;

    logic        clk = 1'b0;
    logic        g_rst;
    logic        signal_input;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        frame_error;
    logic        parity_error;
    logic        busy;
    logic [15:0] frame_count;

    serial_frame_receiver #(.BIT_CYCLES(BC), .DATA_BITS(8)) dut (
        .clk          (clk),
        .g_rst        (g_rst),
        .signal_input (signal_input),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .busy         (busy),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dv_n = 0;
    int         fe_n = 0;
    int         pe_n = 0;
    int         dv_cyc[$];
    logic [7:0] dv_dat[$];

    always @(negedge clk) begin
        if (data_valid) begin
            dv_n = dv_n + 1;
            dv_cyc.push_back(cyc);
            dv_dat.push_back(data_out);
        end
        if (frame_error) fe_n = fe_n + 1;
        if (parity_error) pe_n = pe_n + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        signal_input = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic par,
                        input logic stop, output int t0);
        t0 = cyc;
        hold(1'b0, BC);
        for (int i = 0; i < 8; i++) hold(d[i], BC);
`ifdef SERIAL_RX_PARITY_EN
        hold(par, BC);
`endif
        hold(stop, BC);
    endtask

    int t0, t1, t2, b, f, p;

    initial begin
        g_rst        = 1'b1;
        signal_input = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_perr", parity_error, 0);
        check("rst_busy", busy, 0);
        check("rst_count", frame_count, 0);
        g_rst = 1'b0;
        hold(1'b1, 10);

        // single frame 0xA5
        b = dv_n;
        send(8'hA5, 1'b0, 1'b1, t0);
        hold(1'b1, 4);
        check("a5_pulses", dv_n - b, 1);
        check("a5_when", dv_cyc[b], t0 + DV_OFF);
        check("a5_data", data_out, 8'hA5);
        check("a5_count", frame_count, 1);
        check("a5_busy", busy, 0);

        // 3-cycle glitch: false start
        b = dv_n;
        f = fe_n;
        t0 = cyc;
        hold(1'b0, 3);
        check("gl_busy_up", busy, 1);
        hold(1'b1, 7);
        check("gl_idle_e8", busy, 0);
        hold(1'b1, 10);
        check("gl_no_dv", dv_n - b, 0);
        check("gl_no_fe", fe_n - f, 0);
        check("gl_count", frame_count, 1);

        // 0x3C with stop 0, line held low
        b = dv_n;
        f = fe_n;
        send(8'h3C, 1'b0, 1'b0, t0);
        hold(1'b0, 40);
        check("fe_pulses", fe_n - f, 1);
        check("fe_no_dv", dv_n - b, 0);
        check("fe_data_kept", data_out, 8'hA5);
        check("fe_busy_low", busy, 1);
        check("fe_count", frame_count, 1);
        hold(1'b1, 5);
        check("fe_idle", busy, 0);

        // back-to-back 0x00 0xFF 0x81
        b = dv_n;
        send(8'h00, 1'b0, 1'b1, t0);
        send(8'hFF, 1'b0, 1'b1, t1);
        send(8'h81, 1'b0, 1'b1, t2);
        hold(1'b1, 20);
        check("b2b_pulses", dv_n - b, 3);
        check("b2b_when0", dv_cyc[b], t0 + DV_OFF);
        check("b2b_gap1", dv_cyc[b+1] - dv_cyc[b], FRAME_LEN);
        check("b2b_gap2", dv_cyc[b+2] - dv_cyc[b+1], FRAME_LEN);
        check("b2b_d0", dv_dat[b], 8'h00);
        check("b2b_d1", dv_dat[b+1], 8'hFF);
        check("b2b_d2", dv_dat[b+2], 8'h81);
        check("b2b_count", frame_count, 4);

        // reset during data bit 4 of 0x55
        b = dv_n;
        hold(1'b0, BC);
        for (int i = 0; i < 4; i++) hold(i % 2 == 0, BC);
        hold(1'b1, BC / 2);
        g_rst        = 1'b1;
        signal_input = 1'b1;
        @(posedge clk);
        #1;
        g_rst = 1'b0;
        hold(1'b1, 20);
        check("rs_no_dv", dv_n - b, 0);
        check("rs_count0", frame_count, 0);
        check("rs_data0", data_out, 0);
        check("rs_busy", busy, 0);
        send(8'h12, 1'b0, 1'b1, t0);
        hold(1'b1, 5);
        check("rs_pulses", dv_n - b, 1);
        check("rs_data", data_out, 8'h12);
        check("rs_count1", frame_count, 1);

`ifdef SERIAL_RX_PARITY_EN
        b = dv_n;
        p = pe_n;
        send(8'h07, 1'b1, 1'b1, t0);
        hold(1'b1, 5);
        check("par_ok_dv", dv_n - b, 1);
        check("par_ok_data", data_out, 8'h07);
        check("par_ok_pe", pe_n - p, 0);
        b = dv_n;
        send(8'h07, 1'b0, 1'b1, t0);
        hold(1'b1, 5);
        check("par_bad_pe", pe_n - p, 1);
        check("par_bad_dv", dv_n - b, 0);
        check("par_bad_count", frame_count, 2);
        force dut.frame_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_count;
        send(8'h3A, 1'b0, 1'b1, t0);
        hold(1'b1, 5);
        check("wrap_count", frame_count, 0);
        check("wrap_data", data_out, 8'h3A);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
